// File: rtl/substitui_bytes_inversa_pkg.sv
// Shared definitions for the inverse SubBytes block: FSM encodings and block size.
package substitui_bytes_inversa_pkg;

    typedef enum logic {
        OCIOSO      = 1'b0,
        PROCESSANDO = 1'b1
    } estado_t;

    localparam int unsigned BYTES_BLOCO = 16;

endpackage

// File: rtl/substitui_bytes_inversa_sbox.sv
// Combinational inverse AES S-box (FIPS-197), one byte in, one byte out.
module sbox_inversa (
    input  logic [7:0] entrada,
    output logic [7:0] saida
);

    always_comb begin
        saida = '0;
        case (entrada)
            8'h00: saida = 8'h52; 8'h01: saida = 8'h09; 8'h02: saida = 8'h6a; 8'h03: saida = 8'hd5; 8'h04: saida = 8'h30; 8'h05: saida = 8'h36; 8'h06: saida = 8'ha5; 8'h07: saida = 8'h38;
            8'h08: saida = 8'hbf; 8'h09: saida = 8'h40; 8'h0a: saida = 8'ha3; 8'h0b: saida = 8'h9e; 8'h0c: saida = 8'h81; 8'h0d: saida = 8'hf3; 8'h0e: saida = 8'hd7; 8'h0f: saida = 8'hfb;
            8'h10: saida = 8'h7c; 8'h11: saida = 8'he3; 8'h12: saida = 8'h39; 8'h13: saida = 8'h82; 8'h14: saida = 8'h9b; 8'h15: saida = 8'h2f; 8'h16: saida = 8'hff; 8'h17: saida = 8'h87;
            8'h18: saida = 8'h34; 8'h19: saida = 8'h8e; 8'h1a: saida = 8'h43; 8'h1b: saida = 8'h44; 8'h1c: saida = 8'hc4; 8'h1d: saida = 8'hde; 8'h1e: saida = 8'he9; 8'h1f: saida = 8'hcb;
            8'h20: saida = 8'h54; 8'h21: saida = 8'h7b; 8'h22: saida = 8'h94; 8'h23: saida = 8'h32; 8'h24: saida = 8'ha6; 8'h25: saida = 8'hc2; 8'h26: saida = 8'h23; 8'h27: saida = 8'h3d;
            8'h28: saida = 8'hee; 8'h29: saida = 8'h4c; 8'h2a: saida = 8'h95; 8'h2b: saida = 8'h0b; 8'h2c: saida = 8'h42; 8'h2d: saida = 8'hfa; 8'h2e: saida = 8'hc3; 8'h2f: saida = 8'h4e;
            8'h30: saida = 8'h08; 8'h31: saida = 8'h2e; 8'h32: saida = 8'ha1; 8'h33: saida = 8'h66; 8'h34: saida = 8'h28; 8'h35: saida = 8'hd9; 8'h36: saida = 8'h24; 8'h37: saida = 8'hb2;
            8'h38: saida = 8'h76; 8'h39: saida = 8'h5b; 8'h3a: saida = 8'ha2; 8'h3b: saida = 8'h49; 8'h3c: saida = 8'h6d; 8'h3d: saida = 8'h8b; 8'h3e: saida = 8'hd1; 8'h3f: saida = 8'h25;
            8'h40: saida = 8'h72; 8'h41: saida = 8'hf8; 8'h42: saida = 8'hf6; 8'h43: saida = 8'h64; 8'h44: saida = 8'h86; 8'h45: saida = 8'h68; 8'h46: saida = 8'h98; 8'h47: saida = 8'h16;
            8'h48: saida = 8'hd4; 8'h49: saida = 8'ha4; 8'h4a: saida = 8'h5c; 8'h4b: saida = 8'hcc; 8'h4c: saida = 8'h5d; 8'h4d: saida = 8'h65; 8'h4e: saida = 8'hb6; 8'h4f: saida = 8'h92;
            8'h50: saida = 8'h6c; 8'h51: saida = 8'h70; 8'h52: saida = 8'h48; 8'h53: saida = 8'h50; 8'h54: saida = 8'hfd; 8'h55: saida = 8'hed; 8'h56: saida = 8'hb9; 8'h57: saida = 8'hda;
            8'h58: saida = 8'h5e; 8'h59: saida = 8'h15; 8'h5a: saida = 8'h46; 8'h5b: saida = 8'h57; 8'h5c: saida = 8'ha7; 8'h5d: saida = 8'h8d; 8'h5e: saida = 8'h9d; 8'h5f: saida = 8'h84;
            8'h60: saida = 8'h90; 8'h61: saida = 8'hd8; 8'h62: saida = 8'hab; 8'h63: saida = 8'h00; 8'h64: saida = 8'h8c; 8'h65: saida = 8'hbc; 8'h66: saida = 8'hd3; 8'h67: saida = 8'h0a;
            8'h68: saida = 8'hf7; 8'h69: saida = 8'he4; 8'h6a: saida = 8'h58; 8'h6b: saida = 8'h05; 8'h6c: saida = 8'hb8; 8'h6d: saida = 8'hb3; 8'h6e: saida = 8'h45; 8'h6f: saida = 8'h06;
            8'h70: saida = 8'hd0; 8'h71: saida = 8'h2c; 8'h72: saida = 8'h1e; 8'h73: saida = 8'h8f; 8'h74: saida = 8'hca; 8'h75: saida = 8'h3f; 8'h76: saida = 8'h0f; 8'h77: saida = 8'h02;
            8'h78: saida = 8'hc1; 8'h79: saida = 8'haf; 8'h7a: saida = 8'hbd; 8'h7b: saida = 8'h03; 8'h7c: saida = 8'h01; 8'h7d: saida = 8'h13; 8'h7e: saida = 8'h8a; 8'h7f: saida = 8'h6b;
            8'h80: saida = 8'h3a; 8'h81: saida = 8'h91; 8'h82: saida = 8'h11; 8'h83: saida = 8'h41; 8'h84: saida = 8'h4f; 8'h85: saida = 8'h67; 8'h86: saida = 8'hdc; 8'h87: saida = 8'hea;
            8'h88: saida = 8'h97; 8'h89: saida = 8'hf2; 8'h8a: saida = 8'hcf; 8'h8b: saida = 8'hce; 8'h8c: saida = 8'hf0; 8'h8d: saida = 8'hb4; 8'h8e: saida = 8'he6; 8'h8f: saida = 8'h73;
            8'h90: saida = 8'h96; 8'h91: saida = 8'hac; 8'h92: saida = 8'h74; 8'h93: saida = 8'h22; 8'h94: saida = 8'he7; 8'h95: saida = 8'had; 8'h96: saida = 8'h35; 8'h97: saida = 8'h85;
            8'h98: saida = 8'he2; 8'h99: saida = 8'hf9; 8'h9a: saida = 8'h37; 8'h9b: saida = 8'he8; 8'h9c: saida = 8'h1c; 8'h9d: saida = 8'h75; 8'h9e: saida = 8'hdf; 8'h9f: saida = 8'h6e;
            8'ha0: saida = 8'h47; 8'ha1: saida = 8'hf1; 8'ha2: saida = 8'h1a; 8'ha3: saida = 8'h71; 8'ha4: saida = 8'h1d; 8'ha5: saida = 8'h29; 8'ha6: saida = 8'hc5; 8'ha7: saida = 8'h89;
            8'ha8: saida = 8'h6f; 8'ha9: saida = 8'hb7; 8'haa: saida = 8'h62; 8'hab: saida = 8'h0e; 8'hac: saida = 8'haa; 8'had: saida = 8'h18; 8'hae: saida = 8'hbe; 8'haf: saida = 8'h1b;
            8'hb0: saida = 8'hfc; 8'hb1: saida = 8'h56; 8'hb2: saida = 8'h3e; 8'hb3: saida = 8'h4b; 8'hb4: saida = 8'hc6; 8'hb5: saida = 8'hd2; 8'hb6: saida = 8'h79; 8'hb7: saida = 8'h20;
            8'hb8: saida = 8'h9a; 8'hb9: saida = 8'hdb; 8'hba: saida = 8'hc0; 8'hbb: saida = 8'hfe; 8'hbc: saida = 8'h78; 8'hbd: saida = 8'hcd; 8'hbe: saida = 8'h5a; 8'hbf: saida = 8'hf4;
            8'hc0: saida = 8'h1f; 8'hc1: saida = 8'hdd; 8'hc2: saida = 8'ha8; 8'hc3: saida = 8'h33; 8'hc4: saida = 8'h88; 8'hc5: saida = 8'h07; 8'hc6: saida = 8'hc7; 8'hc7: saida = 8'h31;
            8'hc8: saida = 8'hb1; 8'hc9: saida = 8'h12; 8'hca: saida = 8'h10; 8'hcb: saida = 8'h59; 8'hcc: saida = 8'h27; 8'hcd: saida = 8'h80; 8'hce: saida = 8'hec; 8'hcf: saida = 8'h5f;
            8'hd0: saida = 8'h60; 8'hd1: saida = 8'h51; 8'hd2: saida = 8'h7f; 8'hd3: saida = 8'ha9; 8'hd4: saida = 8'h19; 8'hd5: saida = 8'hb5; 8'hd6: saida = 8'h4a; 8'hd7: saida = 8'h0d;
            8'hd8: saida = 8'h2d; 8'hd9: saida = 8'he5; 8'hda: saida = 8'h7a; 8'hdb: saida = 8'h9f; 8'hdc: saida = 8'h93; 8'hdd: saida = 8'hc9; 8'hde: saida = 8'h9c; 8'hdf: saida = 8'hef;
            8'he0: saida = 8'ha0; 8'he1: saida = 8'he0; 8'he2: saida = 8'h3b; 8'he3: saida = 8'h4d; 8'he4: saida = 8'hae; 8'he5: saida = 8'h2a; 8'he6: saida = 8'hf5; 8'he7: saida = 8'hb0;
            8'he8: saida = 8'hc8; 8'he9: saida = 8'heb; 8'hea: saida = 8'hbb; 8'heb: saida = 8'h3c; 8'hec: saida = 8'h83; 8'hed: saida = 8'h53; 8'hee: saida = 8'h99; 8'hef: saida = 8'h61;
            8'hf0: saida = 8'h17; 8'hf1: saida = 8'h2b; 8'hf2: saida = 8'h04; 8'hf3: saida = 8'h7e; 8'hf4: saida = 8'hba; 8'hf5: saida = 8'h77; 8'hf6: saida = 8'hd6; 8'hf7: saida = 8'h26;
            8'hf8: saida = 8'he1; 8'hf9: saida = 8'h69; 8'hfa: saida = 8'h14; 8'hfb: saida = 8'h63; 8'hfc: saida = 8'h55; 8'hfd: saida = 8'h21; 8'hfe: saida = 8'h0c; 8'hff: saida = 8'h7d;
        endcase
    end

endmodule

// File: rtl/substitui_bytes_inversa.sv
// Sequential InvSubBytes: substitutes BYTES_POR_CICLO bytes per clock through shared S-box lanes.
module substitui_bytes_inversa
    import substitui_bytes_inversa_pkg::*;
#(
    parameter int unsigned BYTES_POR_CICLO = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [127:0] bloco,
    output logic         pronto,
    output logic [127:0] saida,
    output logic         valido
);

    localparam int unsigned GRUPOS  = BYTES_BLOCO / BYTES_POR_CICLO;
    localparam int unsigned CW      = (GRUPOS > 1) ? $clog2(GRUPOS) : 1;
    localparam int unsigned LARGURA = BYTES_POR_CICLO * 8;
    localparam int unsigned DESLOC  = $clog2(LARGURA);
    localparam logic [CW-1:0] ULTIMO = CW'(GRUPOS - 1);

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   contador_q, contador_d;
    logic [127:0]    entrada_q, entrada_d;
    logic [127:0]    resultado_q, resultado_d;
    logic [127:0]    saida_q, saida_d;
    logic            valido_q, valido_d;

    logic [6:0]          base;
    logic [LARGURA-1:0]  grupo_entrada;
    logic [LARGURA-1:0]  grupo_saida;

    assign base          = 7'(contador_q) << DESLOC;
    assign grupo_entrada = entrada_q[base +: LARGURA];

    for (genvar g = 0; g < BYTES_POR_CICLO; g++) begin : g_lane
        sbox_inversa u_sbox (
            .entrada (grupo_entrada[8*g +: 8]),
            .saida   (grupo_saida[8*g +: 8])
        );
    end

    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        entrada_d   = entrada_q;
        resultado_d = resultado_q;
        saida_d     = saida_q;
        valido_d    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    entrada_d  = bloco;
                    contador_d = '0;
                    estado_d   = PROCESSANDO;
                end
            end
            PROCESSANDO: begin
                resultado_d[base +: LARGURA] = grupo_saida;
                // saida takes the merged value so the last group lands in the same edge
                if (contador_q == ULTIMO) begin
                    saida_d    = resultado_d;
                    valido_d   = 1'b1;
                    contador_d = '0;
                    estado_d   = OCIOSO;
                end else begin
                    contador_d = contador_q + CW'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            contador_q  <= '0;
            entrada_q   <= '0;
            resultado_q <= '0;
            saida_q     <= '0;
            valido_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            entrada_q   <= entrada_d;
            resultado_q <= resultado_d;
            saida_q     <= saida_d;
            valido_q    <= valido_d;
        end
    end

    assign pronto = (estado_q == OCIOSO);
    assign saida  = saida_q;
    assign valido = valido_q;

endmodule
